// File: rtl/usb_reset_seq.sv
// Staggered multi-channel reset sequencer clocked by phy_ulpi_clk.
// Channel resets assert asynchronously on reset_n and release synchronously,
// one channel at a time, both after power-on and on software request.
module usb_reset_seq #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STAGGER     = 8,
  parameter int unsigned DEF_HOLD    = 16
) (
  input  logic              phy_ulpi_clk,
  input  logic              reset_n,
  input  logic              sw_rst_req,
  input  logic [CNT_W-1:0]  sw_rst_hold,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              sw_rst_ack,
  output logic              busy,
  output logic              all_released
);

  localparam logic [CNT_W-1:0]  STAGGER_LAST = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0]  PWR_LAST     = CNT_W'(DEF_HOLD - 1);
  localparam logic [NUM_CH-1:0] CH_ONE       = NUM_CH'(1);

  typedef enum logic [2:0] {
    PWR_SYNC,
    PWR_HOLD,
    RELEASE,
    IDLE,
    ASSERT,
    HOLD,
    DONE
  } state_t;

  state_t                state_q, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0]      hold_q, hold_nxt;
  logic [NUM_CH-1:0]     pend_q, pend_nxt, lowest, pend_rel;
  logic [NUM_CH-1:0]     ch_nxt;
  logic                  sw_path_q, sw_path_nxt;
  logic                  done_q;
  state_t                exit_st;

  // Deassertion synchroniser for reset_n
  always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // State register
  always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
    if (!reset_n) state_q <= PWR_SYNC;
    else          state_q <= state_nxt;
  end

  // Next-state, counter, pending-mask and channel update logic
  always_comb begin
    state_nxt   = state_q;
    hold_nxt    = hold_q;
    pend_nxt    = pend_q;
    sw_path_nxt = sw_path_q;
    ch_nxt      = ch_rst_n;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_nxt     = cnt_inc;
    lowest      = pend_q & (~pend_q + CH_ONE);
    pend_rel    = pend_q & ~lowest;
    exit_st     = sw_path_q ? DONE : IDLE;

    case (state_q)
      PWR_SYNC: begin
        cnt_nxt     = '0;
        sw_path_nxt = 1'b0;
        if (sync_q[SYNC_STAGES-1]) state_nxt = PWR_HOLD;
      end
      PWR_HOLD: begin
        sw_path_nxt = 1'b0;
        if (cnt_q == PWR_LAST) begin
          // Power-on mask is all channels; channel 0 releases on entry
          ch_nxt    = ch_rst_n | CH_ONE;
          pend_nxt  = ~CH_ONE;
          cnt_nxt   = '0;
          state_nxt = (~CH_ONE == '0) ? IDLE : RELEASE;
        end
      end
      RELEASE: begin
        if (cnt_q == STAGGER_LAST) begin
          ch_nxt   = ch_rst_n | lowest;
          pend_nxt = pend_rel;
          cnt_nxt  = '0;
          if (pend_rel == '0) state_nxt = exit_st;
        end
      end
      IDLE: begin
        cnt_nxt = '0;
        if (sw_rst_req) begin
          sw_path_nxt = 1'b1;
          if (ch_mask != '0) begin
            pend_nxt  = ch_mask;
            hold_nxt  = (sw_rst_hold == '0) ? CNT_W'(1) : sw_rst_hold;
            state_nxt = ASSERT;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ASSERT: begin
        ch_nxt    = ch_rst_n & ~pend_q;
        cnt_nxt   = '0;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (cnt_q == hold_q - CNT_W'(1)) begin
          ch_nxt    = ch_rst_n | lowest;
          pend_nxt  = pend_rel;
          cnt_nxt   = '0;
          state_nxt = (pend_rel == '0) ? exit_st : RELEASE;
        end
      end
      DONE: begin
        cnt_nxt = '0;
        if (!sw_rst_req) state_nxt = IDLE;
      end
      default: state_nxt = PWR_SYNC;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      hold_q       <= '0;
      pend_q       <= '0;
      sw_path_q    <= 1'b0;
      done_q       <= 1'b0;
      ch_rst_n     <= '0;
      sw_rst_ack   <= 1'b0;
      busy         <= 1'b1;
      all_released <= 1'b0;
    end else begin
      cnt_q        <= cnt_nxt;
      hold_q       <= hold_nxt;
      pend_q       <= pend_nxt;
      sw_path_q    <= sw_path_nxt;
      done_q       <= (state_q == DONE);
      ch_rst_n     <= ch_nxt;
      sw_rst_ack   <= (state_q == DONE) && !done_q;
      busy         <= (state_q != IDLE);
      all_released <= &ch_rst_n;
    end
  end

endmodule
